// File: rtl/nsum_driver.sv
// -----------------------------------------------------------------------------
// nsum_driver
// Initiator for one NSum instance. N values are queued in a small request
// FIFO and issued one at a time as single-cycle N_valid pulses. The driver then
// waits for sum_valid, checks sum against N*(N+1)/2 (mod 2^SUM_W) and reports
// each transaction on the res_* port. A watchdog ends a transaction that gets
// no answer within TIMEOUT cycles.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_n      N value to enqueue
//   req_valid  enqueue strobe, accepted when req_valid & req_ready
//   req_ready  request FIFO not full (registered)
//   N          N presented to NSum (held until the next issue)
//   N_valid    one-cycle issue pulse
//   sum        result from NSum
//   sum_valid  result strobe from NSum
//   res_n      N of the reported transaction
//   res_sum    captured sum (0 on timeout)
//   res_err    captured sum differs from the expected value
//   res_tout   no sum_valid arrived within TIMEOUT cycles
//   res_valid  one-cycle result pulse
//   busy       FSM not idle, or request FIFO non-empty
// -----------------------------------------------------------------------------
module nsum_driver #(
    parameter int N_W     = 3,
    parameter int SUM_W   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_W-1:0]   req_n,
    input  logic             req_valid,
    output logic             req_ready,
    output logic [N_W-1:0]   N,
    output logic             N_valid,
    input  logic [SUM_W-1:0] sum,
    input  logic             sum_valid,
    output logic [N_W-1:0]   res_n,
    output logic [SUM_W-1:0] res_sum,
    output logic             res_err,
    output logic             res_tout,
    output logic             res_valid,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int T_W   = $clog2(TIMEOUT);
    localparam int EXT_W = SUM_W + N_W;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [T_W-1:0]   T_ZERO   = T_W'(0);
    localparam logic [T_W-1:0]   T_ONE    = T_W'(1);
    localparam logic [T_W-1:0]   T_LAST   = T_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    // Expected sum: the product is formed at SUM_W+N_W bits, halved, then
    // truncated, so wrap-around matches NSum's own modulo arithmetic.
    function automatic logic [SUM_W-1:0] calc_exp(input logic [N_W-1:0] n);
        logic [EXT_W-1:0] n_ext;
        logic [EXT_W-1:0] prod;
        n_ext    = {{SUM_W{1'b0}}, n};
        prod     = n_ext * (n_ext + {{(EXT_W-1){1'b0}}, 1'b1});
        calc_exp = SUM_W'(prod >> 1);
    endfunction

    state_t             state_r;
    logic [N_W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic               req_ready_r;
    logic               push_s;
    logic               pop_s;
    logic [N_W-1:0]     head_s;
    logic [T_W-1:0]     timer_r;
    logic [SUM_W-1:0]   exp_r;
    logic [N_W-1:0]     n_r;
    logic               n_valid_r;
    logic [N_W-1:0]     res_n_r;
    logic [SUM_W-1:0]   res_sum_r;
    logic               res_err_r;
    logic               res_tout_r;
    logic               res_valid_r;
    logic               busy_r;

    // FIFO handshake decode and next occupancy.
    always_comb begin
        push_s       = req_valid & req_ready_r;
        pop_s        = (state_r == ST_ISSUE);
        head_s       = mem_r[rd_ptr_r];
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Request FIFO storage, pointers, occupancy and registered ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {N_W{1'b0}};
            end
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= CNT_ZERO;
            req_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= req_n;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_next_s;
            req_ready_r <= (count_next_s != CNT_FULL);
        end
    end

    // Transaction FSM with all issue/result outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            timer_r     <= T_ZERO;
            exp_r       <= {SUM_W{1'b0}};
            n_r         <= {N_W{1'b0}};
            n_valid_r   <= 1'b0;
            res_n_r     <= {N_W{1'b0}};
            res_sum_r   <= {SUM_W{1'b0}};
            res_err_r   <= 1'b0;
            res_tout_r  <= 1'b0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            n_valid_r   <= 1'b0;
            res_valid_r <= 1'b0;
            case (state_r)
                // REPORT falls straight into ISSUE when work is queued, so
                // back-to-back transactions skip the IDLE cycle.
                ST_IDLE, ST_REPORT: begin
                    if (count_r != CNT_ZERO) begin
                        state_r   <= ST_ISSUE;
                        n_r       <= head_s;
                        n_valid_r <= 1'b1;
                        exp_r     <= calc_exp(head_s);
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        busy_r    <= (count_next_s != CNT_ZERO);
                    end
                end
                // sum_valid alongside the N_valid pulse is deliberately ignored.
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                    timer_r <= T_ZERO;
                    busy_r  <= 1'b1;
                end
                // A response on the last timer cycle still counts as a response.
                ST_WAIT: begin
                    busy_r <= 1'b1;
                    if (sum_valid) begin
                        state_r     <= ST_REPORT;
                        res_n_r     <= n_r;
                        res_sum_r   <= sum;
                        res_err_r   <= (sum != exp_r);
                        res_tout_r  <= 1'b0;
                        res_valid_r <= 1'b1;
                    end else if (timer_r == T_LAST) begin
                        state_r     <= ST_REPORT;
                        res_n_r     <= n_r;
                        res_sum_r   <= {SUM_W{1'b0}};
                        res_err_r   <= 1'b0;
                        res_tout_r  <= 1'b1;
                        res_valid_r <= 1'b1;
                    end else begin
                        timer_r <= timer_r + T_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= (count_next_s != CNT_ZERO);
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign N         = n_r;
    assign N_valid   = n_valid_r;
    assign res_n     = res_n_r;
    assign res_sum   = res_sum_r;
    assign res_err   = res_err_r;
    assign res_tout  = res_tout_r;
    assign res_valid = res_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_nsum_driver.sv
// -----------------------------------------------------------------------------
// tb_nsum_driver
// Self-checking bench for nsum_driver. Directed scenarios plus a randomized
// run scored against a queue-based reference of the request/response protocol.
// -----------------------------------------------------------------------------
module tb_nsum_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] N;
    logic       N_valid;
    logic [3:0] sum;
    logic       sum_valid;
    logic [2:0] res_n;
    logic [3:0] res_sum;
    logic       res_err;
    logic       res_tout;
    logic       res_valid;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    nsum_driver #(.N_W(3), .SUM_W(4), .DEPTH(4), .TIMEOUT(32)) dut (
        .clk(clk), .reset(reset),
        .req_n(req_n), .req_valid(req_valid), .req_ready(req_ready),
        .N(N), .N_valid(N_valid),
        .sum(sum), .sum_valid(sum_valid),
        .res_n(res_n), .res_sum(res_sum), .res_err(res_err),
        .res_tout(res_tout), .res_valid(res_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Triangular number reduced to the 4-bit sum width.
    function automatic int tri_mod(input int n);
        return ((n * (n + 1)) / 2) % 16;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_n     = 3'd0;
        sum_valid = 1'b0;
        sum       = 4'd0;
    endtask

    task automatic wait_issue(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (N_valid === 1'b1) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic push(input logic [2:0] n);
        req_n = n; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [2:0] n, input logic [3:0] s, input int delay);
        bit seen;
        logic [3:0] e;
        e = 4'(tri_mod(int'(n)));
        push(n);
        wait_issue(10, seen);
        n_cmp++;
        if (!seen || N !== n) begin n_bad++; $display("FAIL txn_issue: seen=%0b N=%0d want %0d", seen, N, n); end
        repeat (delay) tick();
        sum = s; sum_valid = 1'b1;
        tick();
        sum_valid = 1'b0;
        n_cmp++;
        if ({res_valid, res_n, res_sum, res_err, res_tout} !== {1'b1, n, s, (s != e), 1'b0}) begin
            n_bad++;
            $display("FAIL txn_result: got v=%b n=%0d s=%0d err=%b tout=%b want n=%0d s=%0d err=%b",
                     res_valid, res_n, res_sum, res_err, res_tout, n, s, (s != e));
        end
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2 reset = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({N, N_valid, res_n, res_sum, res_err, res_tout, res_valid, busy} !== 15'd0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_outputs: got outs=%h ready=%b want 0 / 1",
                {N, N_valid, res_n, res_sum, res_err, res_tout, res_valid, busy}, req_ready);
        end
        reset = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({N_valid, res_valid, busy} !== 3'd0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_release: got nv=%b rv=%b busy=%b ready=%b", N_valid, res_valid, busy, req_ready);
        end
    endtask

    task automatic test_single();
        push(3'd5);
        n_cmp++;
        if (N_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL single_idle: nv=%b busy=%b want 0/1", N_valid, busy); end
        tick();
        n_cmp++;
        if ({N_valid, N} !== {1'b1, 3'd5}) begin n_bad++; $display("FAIL single_issue: nv=%b N=%0d want 1/5", N_valid, N); end
        tick();
        n_cmp++;
        if ({N_valid, N, res_valid} !== {1'b0, 3'd5, 1'b0}) begin n_bad++; $display("FAIL single_wait: nv=%b N=%0d rv=%b", N_valid, N, res_valid); end
        sum = 4'hF; sum_valid = 1'b1;
        tick();
        sum_valid = 1'b0;
        n_cmp++;
        if ({res_valid, res_n, res_sum, res_err, res_tout} !== {1'b1, 3'd5, 4'd15, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL single_result: v=%b n=%0d s=%0d err=%b tout=%b want 1/5/15/0/0", res_valid, res_n, res_sum, res_err, res_tout);
        end
        tick();
        n_cmp++;
        if ({res_valid, res_n, res_sum, busy} !== {1'b0, 3'd5, 4'd15, 1'b0}) begin
            n_bad++; $display("FAIL single_hold: v=%b n=%0d s=%0d busy=%b", res_valid, res_n, res_sum, busy);
        end
    endtask

    task automatic test_arith();
        run_txn(3'd7, 4'd12, 1);
        run_txn(3'd4, 4'd9, 2);
        run_txn(3'd0, 4'd0, 1);
        run_txn(3'd6, 4'd5, 3);
    endtask

    task automatic test_fifo_full();
        bit seen;
        logic [2:0] n;
        push(3'd1);
        wait_issue(10, seen);
        n_cmp++;
        if (!seen || N !== 3'd1) begin n_bad++; $display("FAIL full_first_issue: seen=%b N=%0d want 1", seen, N); end
        tick();
        for (int i = 0; i < 5; i++) begin
            req_n = 3'(2 + i); req_valid = 1'b1;
            n_cmp++;
            if (req_ready !== (i < 4)) begin n_bad++; $display("FAIL full_ready_%0d: got %b want %b", i, req_ready, (i < 4)); end
            tick();
        end
        req_valid = 1'b0;
        n_cmp++;
        if ({busy, res_valid} !== 2'b10) begin n_bad++; $display("FAIL full_busy: busy=%b rv=%b", busy, res_valid); end
        sum = 4'd1; sum_valid = 1'b1;
        tick();
        sum_valid = 1'b0;
        n_cmp++;
        if ({res_valid, res_n, res_sum, res_err} !== {1'b1, 3'd1, 4'd1, 1'b0}) begin
            n_bad++; $display("FAIL full_first_result: v=%b n=%0d s=%0d err=%b", res_valid, res_n, res_sum, res_err);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            n = 3'(2 + k);
            n_cmp++;
            if ({N_valid, N} !== {1'b1, n}) begin n_bad++; $display("FAIL full_b2b_issue_%0d: nv=%b N=%0d want 1/%0d", k, N_valid, N, n); end
            tick();
            sum = 4'(tri_mod(int'(n))); sum_valid = 1'b1;
            tick();
            sum_valid = 1'b0;
            n_cmp++;
            if ({res_valid, res_n, res_sum, res_err, res_tout} !== {1'b1, n, 4'(tri_mod(int'(n))), 1'b0, 1'b0}) begin
                n_bad++; $display("FAIL full_order_%0d: v=%b n=%0d s=%0d err=%b want n=%0d", k, res_valid, res_n, res_sum, res_err, n);
            end
            tick();
        end
        tick();
        n_cmp++;
        if ({N_valid, busy, req_ready} !== 3'b001) begin n_bad++; $display("FAIL full_drained: nv=%b busy=%b ready=%b want 0/0/1", N_valid, busy, req_ready); end
    endtask

    task automatic test_timeout();
        bit seen;
        bit early;
        push(3'd3);
        wait_issue(10, seen);
        n_cmp++;
        if (!seen || N !== 3'd3) begin n_bad++; $display("FAIL tout_issue: seen=%b N=%0d want 3", seen, N); end
        early = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (res_valid !== 1'b0) early = 1'b1;
        end
        n_cmp++;
        if (early) begin n_bad++; $display("FAIL tout_early: got res_valid before 32 WAIT cycles, want none"); end
        tick();
        n_cmp++;
        if ({res_valid, res_n, res_sum, res_err, res_tout} !== {1'b1, 3'd3, 4'd0, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL tout_result: v=%b n=%0d s=%0d err=%b tout=%b want 1/3/0/0/1", res_valid, res_n, res_sum, res_err, res_tout);
        end
        tick();
        n_cmp++;
        if ({res_valid, res_tout} !== 2'b01) begin n_bad++; $display("FAIL tout_hold: v=%b tout=%b want 0/1", res_valid, res_tout); end
        // Response arriving on the very last WAIT cycle wins over the timeout.
        push(3'd2);
        wait_issue(10, seen);
        repeat (32) tick();
        sum = 4'd3; sum_valid = 1'b1;
        tick();
        sum_valid = 1'b0;
        n_cmp++;
        if ({res_valid, res_n, res_sum, res_err, res_tout} !== {1'b1, 3'd2, 4'd3, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL tout_edge: v=%b n=%0d s=%0d err=%b tout=%b want 1/2/3/0/0", res_valid, res_n, res_sum, res_err, res_tout);
        end
        tick();
    endtask

    task automatic test_spurious();
        bit seen;
        bit bad;
        bad = 1'b0;
        sum = 4'd7; sum_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (res_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        sum_valid = 1'b0;
        n_cmp++;
        if (bad) begin n_bad++; $display("FAIL spur_idle: got result/busy from idle strobe, want none"); end
        push(3'd6);
        wait_issue(10, seen);
        sum = 4'd0; sum_valid = 1'b1;
        tick();
        sum_valid = 1'b0;
        n_cmp++;
        if (!seen || res_valid !== 1'b0) begin n_bad++; $display("FAIL spur_issue: seen=%b rv=%b want 1/0", seen, res_valid); end
        tick(); tick();
        sum = 4'd5; sum_valid = 1'b1;
        tick();
        n_cmp++;
        if ({res_valid, res_n, res_sum, res_err, res_tout} !== {1'b1, 3'd6, 4'd5, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL spur_result: v=%b n=%0d s=%0d err=%b tout=%b want 1/6/5/0/0", res_valid, res_n, res_sum, res_err, res_tout);
        end
        sum = 4'd9;
        tick();
        sum_valid = 1'b0;
        n_cmp++;
        if ({res_valid, res_sum, busy} !== {1'b0, 4'd5, 1'b0}) begin
            n_bad++; $display("FAIL spur_report: v=%b s=%0d busy=%b want 0/5/0", res_valid, res_sum, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        req_valid = 1'b1;
        req_n = 3'd2; tick();
        req_n = 3'd3; tick();
        req_n = 3'd4; tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({N, N_valid, res_n, res_sum, res_err, res_tout, res_valid, busy} !== 15'd0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL midreset_outputs: outs=%h ready=%b want 0 / 1",
                {N, N_valid, res_n, res_sum, res_err, res_tout, res_valid, busy}, req_ready);
        end
        tick();
        reset = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (N_valid !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin n_bad++; $display("FAIL midreset_quiet: got activity after reset, want FIFO empty and idle"); end
        run_txn(3'd1, 4'd1, 1);
    endtask

    task automatic test_random();
        int         pushes_left;
        int         pend_q[$];
        logic [8:0] exp_q[$];
        logic [8:0] exp_res;
        bit         waiting;
        bit         res_due;
        bit         issued_now;
        int         wcnt;
        int         cur_n;
        int         cyc;
        logic [3:0] e;
        logic [3:0] s;
        pushes_left = 40; waiting = 1'b0; res_due = 1'b0; wcnt = 0; cur_n = 0; cyc = 0;
        idle_inputs();
        while (cyc < 4000 && (pushes_left > 0 || pend_q.size() > 0 || waiting || res_due)) begin
            issued_now = 1'b0;
            if (res_valid === 1'b1 || res_due) begin
                n_cmp++;
                if (!res_due || exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rand_res_unexpected: got res_valid=%b n=%0d, want no result", res_valid, res_n);
                end else begin
                    exp_res = exp_q.pop_front();
                    if (res_valid !== 1'b1 || {res_n, res_sum, res_err, res_tout} !== exp_res) begin
                        n_bad++; $display("FAIL rand_result: got v=%b %h want 1 %h", res_valid, {res_n, res_sum, res_err, res_tout}, exp_res);
                    end
                end
                res_due = 1'b0;
            end
            if (N_valid === 1'b1) begin
                n_cmp++;
                if (waiting || pend_q.size() == 0) begin
                    n_bad++; $display("FAIL rand_issue_unexpected: got N=%0d with nothing pending", N);
                end else begin
                    cur_n = pend_q.pop_front();
                    if (N !== 3'(cur_n)) begin n_bad++; $display("FAIL rand_issue: got N=%0d want %0d", N, cur_n); end
                end
                waiting = 1'b1; wcnt = $urandom_range(1, 6); issued_now = 1'b1;
            end else if (waiting) begin
                n_cmp++;
                if (N !== 3'(cur_n)) begin n_bad++; $display("FAIL rand_n_hold: got N=%0d want %0d", N, cur_n); end
            end
            sum_valid = 1'b0; sum = 4'd0;
            if (waiting && !issued_now) begin
                wcnt--;
                if (wcnt == 0) begin
                    e = 4'(tri_mod(cur_n));
                    s = ($urandom_range(0, 3) == 0) ? (e ^ 4'($urandom_range(1, 15))) : e;
                    sum = s; sum_valid = 1'b1;
                    exp_q.push_back({3'(cur_n), s, (s != e), 1'b0});
                    waiting = 1'b0; res_due = 1'b1;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                sum = 4'($urandom); sum_valid = 1'b1;
            end
            if (pushes_left > 0 && $urandom_range(0, 1) == 0) begin
                req_valid = 1'b1; req_n = 3'($urandom);
                if (req_ready === 1'b1) begin pend_q.push_back(int'(req_n)); pushes_left--; end
            end else begin
                req_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        idle_inputs();
        n_cmp++;
        if (pushes_left > 0 || pend_q.size() > 0 || waiting || res_due || exp_q.size() > 0) begin
            n_bad++; $display("FAIL rand_drain: left=%0d pend=%0d waiting=%b due=%b after %0d cycles, want all done",
                              pushes_left, pend_q.size(), waiting, res_due, cyc);
        end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_arith();
        test_fifo_full();
        test_timeout();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
